// File: rtl/regfile_operand_stage.sv
// Register file plus operand register feeding the ALU a/b inputs.
// R0 reads as zero. One write-back port, two read ports, one-cycle
// registered operands with stall hold.
// Optional build macro REGFILE_BYPASS_EN: same-cycle write data is
// forwarded onto a/b (write-first). Without it reads see the
// pre-write contents (read-before-write).

module regfile_entry #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [N-1:0] wr_data_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] q_q;

  // Storage element: cleared by reset, loaded on its decoded write enable
  always_ff @(posedge clk) begin
    if (reset)        q_q <= '0;
    else if (wr_en_i) q_q <= wr_data_i;
  end

  assign q_o = q_q;
endmodule

module regfile_operand_stage #(
  parameter int N      = 8,
  parameter int R_SIZE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [R_SIZE-1:0] ra_addr,
  input  logic [R_SIZE-1:0] rb_addr,
  input  logic              stall,
  input  logic              we,
  input  logic [R_SIZE-1:0] w_addr,
  input  logic [N-1:0]      w_data,
  output logic [N-1:0]      a,
  output logic [N-1:0]      b,
  output logic              valid
);
  localparam int NREG = 2 ** R_SIZE;

  logic [NREG-1:0][N-1:0] rf;
  logic [N-1:0]           a_d, a_q, b_d, b_q;
  logic                   valid_q;
  logic                   wb_live;

  // A write to R0 is a no-op, so it never counts as a live write-back
  assign wb_live = we && (w_addr != '0);

  // R0 is a constant; every other register is a storage entry
  generate
    for (genvar i = 0; i < NREG; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign rf[i] = '0;
      end else begin : g_ent
        regfile_entry #(.N(N)) u_ent (
          .clk       (clk),
          .reset     (reset),
          .wr_en_i   (wb_live && (w_addr == R_SIZE'(i))),
          .wr_data_i (w_data),
          .q_o       (rf[i])
        );
      end
    end
  endgenerate

  // Read ports, optionally forwarding the write-back in flight this cycle
  always_comb begin
    a_d = rf[ra_addr];
    b_d = rf[rb_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_live && (w_addr == ra_addr)) a_d = w_data;
    if (wb_live && (w_addr == rb_addr)) b_d = w_data;
`endif
  end

  // Operand register: reset wins, stall holds, otherwise capture the read
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= rd_en;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_regfile_operand_stage.sv
// Directed bench for regfile_operand_stage with an expected-operand queue.
module tb_regfile_operand_stage;
  localparam int N = 8, R_SIZE = 3;

  logic              clk = 1'b0;
  logic              reset, rd_en, stall, we;
  logic [R_SIZE-1:0] ra_addr, rb_addr, w_addr;
  logic [N-1:0]      w_data, a, b;
  logic              valid;

  typedef struct packed { logic [N-1:0] ea; logic [N-1:0] eb; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  regfile_operand_stage #(.N(N), .R_SIZE(R_SIZE)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .ra_addr(ra_addr),
    .rb_addr(rb_addr), .stall(stall), .we(we), .w_addr(w_addr),
    .w_data(w_data), .a(a), .b(b), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [R_SIZE-1:0] ad, input logic [N-1:0] d);
    we = 1'b1; w_addr = ad; w_data = d;
    tick();
    we = 1'b0;
  endtask

  // Push expected operands, present addresses for one edge, pop and compare
  task automatic fetch(input string tag, input logic [R_SIZE-1:0] ra, input logic [R_SIZE-1:0] rb,
                       input logic [N-1:0] ea, input logic [N-1:0] eb);
    exp_t e;
    rd_en = 1'b1; ra_addr = ra; rb_addr = rb; stall = 1'b0;
    sb.push_back('{ea: ea, eb: eb});
    tick();
    rd_en = 1'b0; we = 1'b0;
    e = sb.pop_front();
    check({tag, ".valid"}, {7'd0, valid}, 8'd1);
    check({tag, ".a"}, a, e.ea);
    check({tag, ".b"}, b, e.eb);
  endtask

  initial begin
    logic [2*N-1:0] prod;
    logic [N-1:0]   res, hz;
    reset = 1'b1; rd_en = 1'b0; stall = 1'b0; we = 1'b0;
    ra_addr = '0; rb_addr = '0; w_addr = '0; w_data = '0;
    tick(); tick();
    check("rst.a", a, 8'h00);
    check("rst.b", b, 8'h00);
    check("rst.valid", {7'd0, valid}, 8'd0);

    // 1: reset clears registers and discards a same-cycle write
    reset = 1'b0;
    wr(3'd3, 8'h55);
    fetch("pre_rst", 3'd3, 3'd3, 8'h55, 8'h55);
    reset = 1'b1; we = 1'b1; w_addr = 3'd3; w_data = 8'hAA;
    rd_en = 1'b1; ra_addr = 3'd3;
    tick();
    reset = 1'b0; we = 1'b0; rd_en = 1'b0;
    check("rst1.a", a, 8'h00);
    check("rst1.valid", {7'd0, valid}, 8'd0);
    fetch("post_rst", 3'd3, 3'd3, 8'h00, 8'h00);

    // 2: write then read, one edge latency; ALU add of operands
    wr(3'd1, 8'd10);
    wr(3'd2, 8'd5);
    fetch("rd12", 3'd1, 3'd2, 8'd10, 8'd5);
    check("alu_add", a + b, 8'd15);

    // 3: R0 ignores writes, including a same-cycle write during a read
    wr(3'd0, 8'hFF);
    fetch("r0", 3'd0, 3'd0, 8'h00, 8'h00);
    we = 1'b1; w_addr = 3'd0; w_data = 8'hFF;
    fetch("r0_byp", 3'd0, 3'd0, 8'h00, 8'h00);

    // 4: stall holds a/b/valid while writes continue
    wr(3'd4, 8'h44);
    fetch("pre_stall", 3'd1, 3'd2, 8'd10, 8'd5);
    stall = 1'b1; rd_en = 1'b1; ra_addr = 3'd4; rb_addr = 3'd4;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; w_addr = (i == 1) ? 3'd5 : 3'd1; w_data = (i == 1) ? 8'h77 : 8'h60;
      tick();
      check($sformatf("stall%0d.a", i), a, 8'd10);
      check($sformatf("stall%0d.b", i), b, 8'd5);
      check($sformatf("stall%0d.valid", i), {7'd0, valid}, 8'd1);
    end
    we = 1'b0;
    fetch("post_stall", 3'd4, 3'd1, 8'h44, 8'h60);
    fetch("r5", 3'd5, 3'd4, 8'h77, 8'h44);

    // 5: same-cycle read/write hazard
    wr(3'd2, 8'd5);
`ifdef REGFILE_BYPASS_EN
    hz = 8'hC0;
`else
    hz = 8'd5;
`endif
    we = 1'b1; w_addr = 3'd2; w_data = 8'hC0;
    fetch("hazard", 3'd2, 3'd2, hz, hz);
    fetch("hazard_next", 3'd2, 3'd2, 8'hC0, 8'hC0);

    // 6: write-back loop, ALU multiply keeps the low N bits of the product
    wr(3'd1, 8'b0110_0000);
    wr(3'd2, 8'd6);
    fetch("mul_ops", 3'd1, 3'd2, 8'h60, 8'h06);
    prod = 16'h0060 * 16'h0006;
    res  = prod[N-1:0];
    wr(3'd3, res);
    fetch("mul_wb", 3'd3, 3'd3, res, res);

    // rd_en=0 still refreshes a/b but leaves valid low
    rd_en = 1'b0; ra_addr = 3'd1; rb_addr = 3'd2;
    tick();
    check("nord.valid", {7'd0, valid}, 8'd0);
    check("nord.a", a, 8'h60);
    check("nord.b", b, 8'h06);

    // top address
    wr(3'd7, 8'h5A);
    fetch("r7", 3'd7, 3'd0, 8'h5A, 8'h00);

    // reset beats stall
    stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    check("rst_stall.a", a, 8'h00);
    check("rst_stall.valid", {7'd0, valid}, 8'd0);
    fetch("rst_stall_r7", 3'd7, 3'd1, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
